// File: rtl/booth_multiplier.sv
// booth_multiplier: iterative radix-2 Booth signed 32x32 multiplier.
// Produces the low 32 bits of the product and a signed-overflow flag.
// The operation takes 32 shift/add iterations. Completion is marked by a one-cycle ready pulse.
//
// Ports:
//   clock           sole clock, rising edge
//   reset           asynchronous, active-high
//   ctrl_MULT       start pulse; operands are sampled on the same edge
//   data_operandA   multiplicand M, two's complement
//   data_operandB   multiplier Q, two's complement
//   data_result     low word of the product (registered)
//   data_exception  product does not fit in signed 32 bits (registered)
//   data_resultRDY  one-cycle completion pulse (registered)
//
// Optional feature macro: BOOTH_MULT_OVF_EN.
// Define it to enable overflow detection. Left undefined, data_exception is constant 0.
module booth_multiplier (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    localparam int unsigned W  = 32;
    localparam int unsigned AW = W + 1;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   a_q, a_d;
    logic [W-1:0]    q_q, q_d;
    logic            q1_q, q1_d;
    logic [AW-1:0]   m_q, m_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    result_d;
    logic            exc_d;
    logic            rdy_d;

    logic [AW-1:0]   sum_c;
    logic [AW-1:0]   a_sh_c;
    logic [W-1:0]    q_sh_c;
    logic            ovf_c;
    logic            last_iter_c;

    // One Booth iteration: add/subtract, then arithmetic shift of {A,Q,q_1}.
    always_comb begin
        sum_c = a_q;
        if (q_q[0] == 1'b0 && q1_q == 1'b1) begin
            sum_c = a_q + m_q;
        end else if (q_q[0] == 1'b1 && q1_q == 1'b0) begin
            sum_c = a_q - m_q;
        end
        a_sh_c = {sum_c[AW-1], sum_c[AW-1:1]};
        q_sh_c = {sum_c[0], q_q[W-1:1]};
    end

    // Overflow: the high product word must be the sign extension of the low word.
`ifdef BOOTH_MULT_OVF_EN
    assign ovf_c = (a_sh_c[W-1:0] != {W{q_sh_c[W-1]}});
`else
    assign ovf_c = 1'b0;
`endif

    // The final iteration runs when cnt_q is 31; that edge enters DONE.
    assign last_iter_c = (state_q == RUN) && (cnt_q == CW'(W - 1));

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start pulse overrides every state, including the DONE entry.
    always_comb begin
        state_d = state_q;
        if (ctrl_MULT) begin
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     state_d = last_iter_c ? DONE : RUN;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values for the datapath and the registered outputs
    always_comb begin
        a_d      = a_q;
        q_d      = q_q;
        q1_d     = q1_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        result_d = data_result;
        exc_d    = data_exception;
        rdy_d    = 1'b0;
        if (ctrl_MULT) begin
            a_d   = '0;
            q_d   = data_operandB;
            q1_d  = 1'b0;
            m_d   = {data_operandA[W-1], data_operandA};
            cnt_d = '0;
        end else if (state_q == RUN) begin
            a_d   = a_sh_c;
            q_d   = q_sh_c;
            q1_d  = q_q[0];
            cnt_d = cnt_q + CW'(1);
            if (last_iter_c) begin
                result_d = q_sh_c;
                exc_d    = ovf_c;
                rdy_d    = 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q            <= '0;
            q_q            <= '0;
            q1_q           <= 1'b0;
            m_q            <= '0;
            cnt_q          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            a_q            <= a_d;
            q_q            <= q_d;
            q1_q           <= q1_d;
            m_q            <= m_d;
            cnt_q          <= cnt_d;
            data_result    <= result_d;
            data_exception <= exc_d;
            data_resultRDY <= rdy_d;
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier.
// Expected products are pushed to a scoreboard queue when an operation starts.
// They are popped and compared on each ready pulse.
module tb_booth_multiplier;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q[$];
    logic        prev_rdy;

    booth_multiplier dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: {exception, low word} from a full 64-bit signed product.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] p;
        logic               exc;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        p   = sa * sb;
`ifdef BOOTH_MULT_OVF_EN
        exc = (p[63:32] != {32{p[31]}});
`else
        exc = 1'b0;
`endif
        return {exc, p[31:0]};
    endfunction

    // Scoreboard: every ready pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        if (data_resultRDY) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rdy: pulse with result=%h exc=%b, no operation pending",
                         data_result, data_exception);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if (data_result !== e[31:0]) begin
                    failures++;
                    $display("FAIL result: got %h expected %h", data_result, e[31:0]);
                end
                checks++;
                if (data_exception !== e[32]) begin
                    failures++;
                    $display("FAIL exception: got %b expected %b (result %h)",
                             data_exception, e[32], e[31:0]);
                end
            end
            checks++;
            if (prev_rdy === 1'b1) begin
                failures++;
                $display("FAIL rdy_width: got ready high two cycles in a row, expected one");
            end
        end
        prev_rdy = data_resultRDY;
    end

    // Drive one start pulse from a negedge. Returns at the negedge after the start edge.
    task automatic pulse(input logic [31:0] a, input logic [31:0] b, input bit push);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        if (push) exp_q.push_back(model(a, b));
        @(negedge clock);
        ctrl_MULT = 1'b0;
    endtask

    // Count edges after the start edge until ready is seen, bounded.
    task automatic wait_rdy(output int edges);
        edges = 0;
        while (!data_resultRDY && edges < 40) begin
            @(negedge clock);
            edges++;
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        prev_rdy      = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (data_result !== 32'h0) begin
            failures++;
            $display("FAIL reset_result: got %h expected 0", data_result);
        end
        checks++;
        if (data_exception !== 1'b0) begin
            failures++;
            $display("FAIL reset_exception: got %b expected 0", data_exception);
        end
        checks++;
        if (data_resultRDY !== 1'b0) begin
            failures++;
            $display("FAIL reset_rdy: got %b expected 0", data_resultRDY);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Single multiply with latency check; pulse must be exactly 32 edges after start.
    task automatic test_op(input logic [31:0] a, input logic [31:0] b, input string name);
        int edges;
        pulse(a, b, 1'b1);
        wait_rdy(edges);
        checks++;
        if (!data_resultRDY) begin
            failures++;
            $display("FAIL %s_timeout: no ready after %0d edges, expected at 32", name, edges);
        end else if (edges != 32) begin
            failures++;
            $display("FAIL %s_latency: got %0d edges expected 32", name, edges);
        end
        @(negedge clock);
    endtask

    task automatic test_basic_hold();
        test_op(32'd3, 32'd4, "mul3x4");
        repeat (5) @(negedge clock);
        checks++;
        if (data_result !== 32'd12 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
            failures++;
            $display("FAIL hold: got result=%h exc=%b rdy=%b expected 0000000c/0/0",
                     data_result, data_exception, data_resultRDY);
        end
    endtask

    task automatic test_signed();
        test_op(32'hFFFF_FFF9, 32'd6, "neg7x6");
        test_op(32'hFFFF_FFF9, 32'hFFFF_FFFA, "neg7xneg6");
        test_op(32'h0001_0000, 32'h0001_0000, "ovf_2p32");
        test_op(32'h8000_0000, 32'hFFFF_FFFF, "minxneg1");
        test_op(32'h8000_0000, 32'd1, "minx1");
        test_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, "maxxmax");
        test_op(32'h0000_0000, 32'h8000_0000, "zeroxmin");
    endtask

    // Second start at cycle 10 aborts the first; only the second result appears.
    task automatic test_abort();
        int edges;
        pulse(32'd5, 32'd5, 1'b0);
        repeat (9) @(negedge clock);
        pulse(32'd2, 32'd9, 1'b1);
        wait_rdy(edges);
        checks++;
        if (!data_resultRDY || edges != 32) begin
            failures++;
            $display("FAIL abort_latency: got rdy=%b after %0d edges expected 1 at 32",
                     data_resultRDY, edges);
        end
        repeat (40) @(negedge clock);
    endtask

    // New start on the edge that leaves DONE.
    task automatic test_back_to_back();
        int edges;
        pulse(32'd11, 32'd13, 1'b1);
        wait_rdy(edges);
        pulse(32'hFFFF_FFFE, 32'd21, 1'b1);
        wait_rdy(edges);
        checks++;
        if (!data_resultRDY || edges != 32) begin
            failures++;
            $display("FAIL b2b_latency: got rdy=%b after %0d edges expected 1 at 32",
                     data_resultRDY, edges);
        end
        @(negedge clock);
    endtask

    // ctrl_MULT held for three edges; only the last operand pair completes.
    task automatic test_held_start();
        int edges;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd3;
        @(negedge clock);
        data_operandA = 32'd17;
        @(negedge clock);
        data_operandA = 32'd19;
        data_operandB = 32'hFFFF_FFFD;
        exp_q.push_back(model(32'd19, 32'hFFFF_FFFD));
        @(negedge clock);
        ctrl_MULT = 1'b0;
        wait_rdy(edges);
        checks++;
        if (!data_resultRDY || edges != 32) begin
            failures++;
            $display("FAIL held_latency: got rdy=%b after %0d edges expected 1 at 32",
                     data_resultRDY, edges);
        end
        @(negedge clock);
    endtask

    // Reset mid-operation clears outputs at once and suppresses the pulse.
    task automatic test_mid_reset();
        pulse(32'd100, 32'd100, 1'b0);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got result=%h exc=%b rdy=%b expected 0/0/0",
                     data_result, data_exception, data_resultRDY);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        checks++;
        if (data_result !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_result: got %h expected 0", data_result);
        end
        test_op(32'd7, 32'd8, "mul7x8");
    endtask

    initial begin
        test_reset();
        test_basic_hold();
        test_signed();
        test_abort();
        test_back_to_back();
        test_held_start();
        test_mid_reset();
        repeat (5) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending results expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_multiplier.md
# booth_multiplier

Iterative radix-2 Booth signed 32×32 multiplier for the execute stage. It sits beside the ALU shift datapath and consumes the same 32-bit operand buses. It shifts an accumulator/multiplier pair one bit per cycle and produces the low 32 bits of the product plus a signed-overflow flag. A single-cycle start pulse launches it, and it signals completion with a one-cycle ready pulse.

## Interface
Parameters:
- none; width fixed at 32, iteration count fixed at 32.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE and clears all outputs.
- ctrl_MULT  input  1  start pulse; operands sampled on the same edge.
- data_operandA  input  32  multiplicand M, two's complement.
- data_operandB  input  32  multiplier Q, two's complement.
- data_result  output  32  low word of the product; registered.
- data_exception  output  1  product does not fit in signed 32 bits; registered.
- data_resultRDY  output  1  one-cycle completion pulse; registered.

## Operation
- State: 2-bit FSM with states IDLE, RUN, DONE.
- Registers:
  - A: 33-bit signed accumulator.
  - Q: 32-bit multiplier.
  - q_1: 1-bit Booth history.
  - M: 33-bit sign-extended multiplicand.
  - cnt: 6-bit iteration counter.
- Start: ctrl_MULT=1 at an edge in any state does the following:
  - loads A=0, Q=data_operandB, q_1=0, M=sext(data_operandA), cnt=0;
  - moves to RUN.
- RUN, once per edge:
  - Select the step from {Q[0],q_1}: 01 gives A=A+M; 10 gives A=A−M; 00 and 11 leave A unchanged.
  - Then arithmetic-shift {A,Q,q_1} right by 1. A[32] is replicated; 33-bit arithmetic wraps modulo 2^33.
  - cnt increments. After the 32nd iteration (cnt reaches 32), go to DONE.
- Completion, on the edge that enters DONE:
  - data_result = Q, the product low word.
  - data_exception = overflow flag (see Configuration).
  - data_resultRDY = 1.
- DONE: lasts exactly one cycle, then returns to IDLE and clears data_resultRDY.
- Holding: data_result and data_exception keep their value until the next completion or reset.
- Restart: ctrl_MULT while in RUN or DONE aborts the current operation and restarts with the new operands.
  - No ready pulse is issued for the aborted operation.
  - If the restart edge coincides with the DONE-entry edge, the restart wins and no pulse is issued.
- ctrl_MULT held high for N cycles restarts on every edge. The result comes 32 cycles after the last high edge.
- Reset mid-operation: the operation is discarded and outputs go to 0 immediately (async). With reset high, no ready pulse appears.

## Timing
- Reset values: state=IDLE; data_result=0, data_exception=0, data_resultRDY=0; A, Q, q_1, M, cnt all 0.
- Latency: with ctrl_MULT sampled at edge E0, iterations occur at E1..E32.
  - data_resultRDY is high in the cycle after E32, i.e. 32 cycles after the start edge.
  - data_resultRDY falls at E33.
- Throughput: one multiply per 33 cycles. A back-to-back start is accepted at E33, or earlier by aborting.
- Outputs are glitch-free register outputs; no combinational input-to-output path.

## Configuration
- Macro: BOOTH_MULT_OVF_EN.
- Defined:
  - data_exception = 1 iff the 64-bit product {A[31:0],Q} is not the sign extension of Q[31].
  - Equivalently, A[31:0] ≠ {32{Q[31]}}.
- Undefined: the overflow logic is absent and data_exception is constant 0. All other behaviour and timing are identical.

## Test plan
- Reset, then A=3, B=4, pulse ctrl_MULT -> resultRDY pulse exactly 32 cycles later, result=12, exception=0, outputs hold afterwards.
- A=−7 (0xFFFFFFF9), B=6 -> result=0xFFFFFFD6 (−42), exception=0; repeat with B=−6 -> result=42.
- A=0x00010000, B=0x00010000 -> result=0, exception=1 (macro defined) / 0 (undefined).
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1 (defined). A=0x80000000, B=1 -> result=0x80000000, exception=0.
- Start 5×5, then at cycle 10 pulse 2×9 -> single resultRDY 32 cycles after the second pulse with result=18; no pulse for 25.
- Start 100×100, assert reset at cycle 15 for 2 cycles -> result/exception/RDY go 0 immediately, no pulse follows; a fresh 7×8 after release yields 56.
